// File: rtl/mux_tree_pkg.sv
// Shared constants and sizing helpers for the pipelined mux tree.
package mux_tree_pkg;

  localparam int MUX_TREE_MAX_SEL_W = 6;

  function automatic int n_inputs(input int sel_w);
    return 1 << sel_w;
  endfunction

  function automatic int level_nodes(input int sel_w, input int lvl);
    return (1 << sel_w) >> (lvl + 1);
  endfunction

endpackage

// File: rtl/mux_tree_mux2_reg.sv
// One tree node: 2:1 select into a load-enabled register with synchronous reset.
module mux2_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_i,
  input  logic              sel_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q, data_d;

  assign data_d = sel_i ? b_i : a_i;

  always_ff @(posedge clk) begin
    if (rst)       data_q <= '0;
    else if (ld_i) data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipelined_mux_tree.sv
// N:1 mux as a binary tree with one register level per select bit and valid/ready flow control.
// Optional MUX_TREE_TAG_EN carries the full select to an extra sel_o output.
module pipelined_mux_tree
  import mux_tree_pkg::*;
#(
  parameter int SEL_W  = 3,
  parameter int DATA_W = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [SEL_W-1:0]                   s,
  input  logic [n_inputs(SEL_W)*DATA_W-1:0]  i,
  output logic                               out_valid,
  input  logic                               out_ready,
`ifdef MUX_TREE_TAG_EN
  output logic [SEL_W-1:0]                   sel_o,
`endif
  output logic [DATA_W-1:0]                  y
);

  localparam int N = n_inputs(SEL_W);

  if (SEL_W < 1 || SEL_W > MUX_TREE_MAX_SEL_W) begin : g_bad_sel_w
    $error("pipelined_mux_tree: SEL_W out of range");
  end

  logic [SEL_W-1:0] vld_q, vld_d, adv, ld, node_sel;
  logic [SEL_W-1:0] sel_q [SEL_W];
  logic [SEL_W-1:0] sel_d [SEL_W];
  // All node registers flattened: level l starts at N - (N >> l).
  logic [DATA_W-1:0] node_q [N-1];

  // Unrolled ready chain: a level may move unless every level from it to the output is full and the sink stalls.
  always_comb begin
    logic full;
    adv  = '0;
    full = vld_q[SEL_W-1];
    for (int l = SEL_W-1; l >= 0; l--) begin
      adv[l] = out_ready | ~full;
      full   = full & vld_q[l];
    end
  end

  assign in_ready = ~vld_q[0] | adv[0];

  always_comb begin
    ld       = '0;
    node_sel = '0;
    ld[0]       = in_valid & in_ready;
    node_sel[0] = s[0];
    for (int l = 1; l < SEL_W; l++) begin
      ld[l]       = vld_q[l-1] & adv[l-1];
      node_sel[l] = sel_q[l-1][l];
    end
    for (int l = 0; l < SEL_W; l++)
      vld_d[l] = ld[l] ? 1'b1 : (adv[l] ? 1'b0 : vld_q[l]);
  end

  always_comb begin
    sel_d[0] = s;
    for (int l = 1; l < SEL_W; l++) sel_d[l] = sel_q[l-1];
`ifndef MUX_TREE_TAG_EN
    // Only the still-unresolved select bits are kept; resolved bits become constant zero.
    for (int l = 0; l < SEL_W; l++)
      for (int b = 0; b <= l; b++) sel_d[l][b] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int l = 0; l < SEL_W; l++) sel_q[l] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int l = 0; l < SEL_W; l++)
        if (ld[l]) sel_q[l] <= sel_d[l];
    end
  end

  for (genvar l = 0; l < SEL_W; l++) begin : g_lvl
    localparam int NODES = level_nodes(SEL_W, l);
    localparam int OFF   = N - (N >> l);
    for (genvar k = 0; k < NODES; k++) begin : g_node
      logic [DATA_W-1:0] a, b;
      if (l == 0) begin : g_leaf
        assign a = i[(2*k)*DATA_W +: DATA_W];
        assign b = i[(2*k+1)*DATA_W +: DATA_W];
      end else begin : g_inner
        assign a = node_q[OFF - (N >> l) + 2*k];
        assign b = node_q[OFF - (N >> l) + 2*k + 1];
      end
      mux2_reg #(.DATA_W(DATA_W)) u_node (
        .clk   (clk),
        .rst   (rst),
        .ld_i  (ld[l]),
        .sel_i (node_sel[l]),
        .a_i   (a),
        .b_i   (b),
        .q_o   (node_q[OFF + k])
      );
    end
  end

  assign out_valid = vld_q[SEL_W-1];
  assign y         = node_q[N-2];
`ifdef MUX_TREE_TAG_EN
  assign sel_o     = sel_q[SEL_W-1];
`endif

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// Bench for pipelined_mux_tree: directed SEL_W=3 scenarios, SEL_W=1 latency, SEL_W=4 random scoreboard.
module tb_pipelined_mux_tree;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic        iv3 = 1'b0, ir3, ov3, or3 = 1'b0;
  logic [2:0]  s3 = '0;
  logic [63:0] i3 = 64'h7766554433221100;
  logic [7:0]  y3;
  logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b0;
  logic [3:0]  s4 = '0;
  logic [127:0] i4 = '0;
  logic [7:0]  y4;
  logic        iv1 = 1'b0, ir1, ov1, or1 = 1'b0;
  logic [0:0]  s1 = '0;
  logic [15:0] i1 = '0;
  logic [7:0]  y1;
`ifdef MUX_TREE_TAG_EN
  logic [2:0]  sel3;
  logic [3:0]  sel4;
  logic [0:0]  sel1;
`endif

  pipelined_mux_tree #(.SEL_W(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .s(s3), .i(i3),
    .out_valid(ov3), .out_ready(or3),
`ifdef MUX_TREE_TAG_EN
    .sel_o(sel3),
`endif
    .y(y3));

  pipelined_mux_tree #(.SEL_W(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .s(s4), .i(i4),
    .out_valid(ov4), .out_ready(or4),
`ifdef MUX_TREE_TAG_EN
    .sel_o(sel4),
`endif
    .y(y4));

  pipelined_mux_tree #(.SEL_W(1), .DATA_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .s(s1), .i(i1),
    .out_valid(ov1), .out_ready(or1),
`ifdef MUX_TREE_TAG_EN
    .sel_o(sel1),
`endif
    .y(y1));

  // Reference: the selected input is simply byte s of the packed bus.
  function automatic logic [7:0] pick3(input logic [2:0] sel);
    return i3[sel*8 +: 8];
  endfunction

  task automatic test_reset();
    rst = 1'b1; iv3 = 1'b1; s3 = 3'd5; or3 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; iv3 = 1'b0;
    #1;
    vectors++; if (ov3 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov3); end
    vectors++; if (y3 !== 8'h00) begin errors++; $display("FAIL reset_y: got %h want 00", y3); end
    vectors++; if (ir3 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", ir3); end
    for (int w = 0; w < 5; w++) begin
      @(negedge clk); #1;
      vectors++; if (ov3 !== 1'b0) begin errors++; $display("FAIL reset_ignored_in: w%0d out_valid %b want 0", w, ov3); end
    end
  endtask

  task automatic test_single();
    or3 = 1'b1;
    for (int w = 0; w < 7; w++) begin
      @(negedge clk);
      iv3 = (w == 0); s3 = 3'd5;
      #1;
      vectors++;
      if (ov3 !== (w == 3)) begin errors++; $display("FAIL single_valid: w%0d got %b want %b", w, ov3, (w == 3)); end
      if (w == 3) begin
        vectors++; if (y3 !== 8'h55) begin errors++; $display("FAIL single_y: got %h want 55", y3); end
      end
    end
  endtask

  task automatic test_stream();
    or3 = 1'b1;
    for (int w = 0; w < 16; w++) begin
      @(negedge clk);
      iv3 = (w < 8); s3 = 3'(w);
      #1;
      if (w < 8) begin
        vectors++; if (ir3 !== 1'b1) begin errors++; $display("FAIL stream_in_ready: w%0d got %b want 1", w, ir3); end
      end
      vectors++;
      if (ov3 !== (w >= 3 && w <= 10)) begin errors++; $display("FAIL stream_valid: w%0d got %b", w, ov3); end
      if (w >= 3 && w <= 10) begin
        vectors++; if (y3 !== pick3(3'(w-3))) begin errors++; $display("FAIL stream_y: w%0d got %h want %h", w, y3, pick3(3'(w-3))); end
      end
    end
    iv3 = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int w = 0; w < 12; w++) begin
      @(negedge clk);
      iv3 = (w < 3); s3 = 3'(w + 1); or3 = (w >= 8);
      #1;
      if (w < 3) begin
        vectors++; if (ir3 !== 1'b1) begin errors++; $display("FAIL bp_fill_ready: w%0d got %b want 1", w, ir3); end
      end else if (w < 8) begin
        vectors++;
        if (ov3 !== 1'b1 || y3 !== 8'h11 || ir3 !== 1'b0) begin
          errors++; $display("FAIL bp_hold: w%0d valid %b y %h ready %b want 1 11 0", w, ov3, y3, ir3);
        end
      end else if (w < 11) begin
        vectors++;
        if (ov3 !== 1'b1 || y3 !== pick3(3'(w - 7))) begin
          errors++; $display("FAIL bp_drain: w%0d valid %b y %h want 1 %h", w, ov3, y3, pick3(3'(w - 7)));
        end
      end else begin
        vectors++; if (ov3 !== 1'b0) begin errors++; $display("FAIL bp_dup: got valid %b want 0", ov3); end
      end
    end
    iv3 = 1'b0;
  endtask

  task automatic test_bubble();
    logic [2:0] order [3] = '{3'd4, 3'd6, 3'd2};
    or3 = 1'b0;
    for (int w = 0; w < 10; w++) begin
      @(negedge clk);
      iv3 = (w == 0 || w == 3 || w == 4);
      s3  = (w == 0) ? 3'd4 : (w == 3) ? 3'd6 : 3'd2;
      or3 = (w >= 6);
      #1;
      if (w == 3 || w == 4) begin
        vectors++; if (ir3 !== 1'b1) begin errors++; $display("FAIL bubble_accept: w%0d ready %b want 1", w, ir3); end
      end
      if (w == 5) begin
        vectors++; if (ir3 !== 1'b0) begin errors++; $display("FAIL bubble_full: ready %b want 0", ir3); end
      end
      if (w >= 3 && w <= 5) begin
        vectors++;
        if (ov3 !== 1'b1 || y3 !== pick3(3'd4)) begin errors++; $display("FAIL bubble_stall: w%0d valid %b y %h want 1 %h", w, ov3, y3, pick3(3'd4)); end
      end
      if (w >= 6 && w <= 8) begin
        vectors++;
        if (ov3 !== 1'b1 || y3 !== pick3(order[w-6])) begin errors++; $display("FAIL bubble_order: w%0d valid %b y %h want 1 %h", w, ov3, y3, pick3(order[w-6])); end
      end
      if (w == 9) begin
        vectors++; if (ov3 !== 1'b0) begin errors++; $display("FAIL bubble_extra: valid %b want 0", ov3); end
      end
    end
    iv3 = 1'b0;
  endtask

  task automatic test_reset_mid();
    or3 = 1'b0;
    for (int w = 0; w < 11; w++) begin
      @(negedge clk);
      iv3 = (w < 3); s3 = 3'(w + 1); rst = (w == 3); or3 = (w >= 4);
      #1;
      if (w == 4) begin
        vectors++;
        if (ov3 !== 1'b0 || y3 !== 8'h00 || ir3 !== 1'b1) begin
          errors++; $display("FAIL rst_mid: valid %b y %h ready %b want 0 00 1", ov3, y3, ir3);
        end
      end else if (w > 4) begin
        vectors++; if (ov3 !== 1'b0) begin errors++; $display("FAIL rst_stale: w%0d valid %b want 0", w, ov3); end
      end
    end
    rst = 1'b0; iv3 = 1'b0;
  endtask

  task automatic test_sel1();
    logic [7:0] prev = '0;
    or1 = 1'b1;
    for (int w = 0; w <= 20; w++) begin
      @(negedge clk);
      iv1 = (w < 20); s1 = 1'($urandom); i1 = 16'($urandom);
      #1;
      vectors++;
      if (ov1 !== (w > 0)) begin errors++; $display("FAIL sel1_valid: w%0d got %b want %b", w, ov1, (w > 0)); end
      if (w > 0) begin
        vectors++; if (y1 !== prev) begin errors++; $display("FAIL sel1_y: w%0d got %h want %h", w, y1, prev); end
      end
      prev = i1[s1*8 +: 8];
    end
    iv1 = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] qd[$];
    logic [3:0] qs[$];
    logic [7:0] py = '0;
    logic       stall = 1'b0;
    int acc = 0, cyc = 0;
    while ((acc < 1000 || qd.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      iv4 = (acc < 1000) && ($urandom_range(0, 3) != 0);
      s4  = 4'($urandom);
      for (int b = 0; b < 16; b++) i4[b*8 +: 8] = 8'($urandom);
      or4 = ($urandom_range(0, 9) < 6);
      #1;
      if (stall) begin
        vectors++;
        if (ov4 !== 1'b1 || y4 !== py) begin errors++; $display("FAIL rand_stall: valid %b y %h want 1 %h", ov4, y4, py); end
      end
      if (ov4 === 1'b1 && or4) begin
        vectors++;
        if (qd.size() == 0) begin
          errors++; $display("FAIL rand_spurious: y %h with empty scoreboard", y4);
        end else begin
          logic [7:0] ed;
          logic [3:0] es;
          ed = qd.pop_front(); es = qs.pop_front();
          if (y4 !== ed) begin errors++; $display("FAIL rand_y: got %h want %h", y4, ed); end
`ifdef MUX_TREE_TAG_EN
          vectors++;
          if (sel4 !== es) begin errors++; $display("FAIL rand_sel_o: got %h want %h", sel4, es); end
`else
          if (es > 4'd15) begin errors++; $display("FAIL rand_sel_range: got %h", es); end
`endif
        end
      end
      if (iv4 && ir4 === 1'b1) begin
        qd.push_back(i4[s4*8 +: 8]); qs.push_back(s4); acc++;
      end
      stall = (ov4 === 1'b1) && !or4;
      py = y4;
    end
    iv4 = 1'b0;
    vectors++;
    if (cyc >= 20000) begin errors++; $display("FAIL rand_timeout: accepted %0d pending %0d", acc, qd.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_bubble();
    test_reset_mid();
    test_sel1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
